bitty_fetch: RTL

BITTY_FETCH -- requirements
Module: bitty_fetch

---
 rtl/bitty_fetch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bitty_fetch.sv
// bitty_fetch: instruction fetch/issue sequencer with a local 2**ADDR_W x 16 program memory.
// Define BITTY_FETCH_BRANCH_EN to decode words with bits[1:0]=2'b10 as conditional branches.
module bitty_fetch #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              done,
    input  logic [15:0]       reg_c,
    output logic [15:0]       instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              timeout
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]       HALT_WORD = 16'hFFFF;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       rdata_q;
    logic [15:0]       mem [DEPTH];

    logic              stopped;
    logic              mem_we;
    logic              pc_at_end;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_branch;
    logic              take_branch;
    logic [ADDR_W-1:0] branch_tgt;

    assign stopped   = (state_q == S_IDLE) || (state_q == S_HALT);
    assign mem_we    = stopped && load_en;
    assign pc_at_end = (pc_q == LAST_ADDR);
    assign pc_inc    = pc_q + ADDR_W'(1);

`ifdef BITTY_FETCH_BRANCH_EN
    logic [ADDR_W+7:0] tgt_ext;

    assign tgt_ext    = {{ADDR_W{1'b0}}, rdata_q[15:8]};
    assign branch_tgt = tgt_ext[ADDR_W-1:0];
    assign is_branch  = (rdata_q[1:0] == 2'b10);

    always_comb begin
        unique case (rdata_q[3:2])
            2'b00:   take_branch = 1'b1;
            2'b01:   take_branch = (reg_c == 16'h0000);
            2'b10:   take_branch = (reg_c != 16'h0000);
            default: take_branch = 1'b0;
        endcase
    end
`else
    logic unused_reg_c;

    assign unused_reg_c = ^reg_c;
    assign is_branch    = 1'b0;
    assign take_branch  = 1'b0;
    assign branch_tgt   = '0;
`endif

    // NOTE: the program memory and its read register are deliberately not reset;
    // a reset branch would turn the array into thousands of flops instead of a RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
        if (state_q == S_FETCH) begin
            rdata_q <= mem[pc_q];
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch;
    // combinational logic uses blocking '=', the state registers below use '<='.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (rdata_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (is_branch) begin
                    if (take_branch) begin
                        pc_d    = branch_tgt;
                        state_d = S_FETCH;
                    end else if (pc_at_end) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end else begin
                    instr_d = rdata_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    if (pc_at_end) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= 16'h0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Status flags decode straight from the state register so reset clears them at once.
    assign instruction = instr_q;
    assign inst_valid  = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign halted      = (state_q == S_HALT);
    assign timeout     = timeout_q;

endmodule
